// File: rtl/cam_pkg.sv
// Shared types and default parameters for the CAM data-store write sequencer.
package cam_pkg;
  localparam int NUM_SUB_D     = 16;
  localparam int DATA_W_D      = 16;
  localparam int ADDR_HI_W_D   = 5;
  localparam int ADDR_LO_W_D   = 5;
  localparam int ACK_TIMEOUT_D = 15;
  localparam int MAX_RETRY_D   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_WRITE,
    S_WAIT_ACK,
    S_VEC_DONE,
    S_FINISH
  } cam_seq_state_t;
endpackage

// File: rtl/cam_mask_prio_enc.sv
// Finds the lowest set mask bit at or above start_idx. start_idx == N means "none left".
module cam_mask_prio_enc #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [IW:0]   start_idx,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest qualifying bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(start_idx))) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/cam_store_sequencer.sv
// Writes a run of vectors to each enabled CAM subarray in turn, with ack timeout,
// bounded retry and sticky error capture.
module cam_store_sequencer
  import cam_pkg::*;
#(
  parameter int NUM_SUB     = NUM_SUB_D,
  parameter int DATA_W      = DATA_W_D,
  parameter int ADDR_HI_W   = ADDR_HI_W_D,
  parameter int ADDR_LO_W   = ADDR_LO_W_D,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_D,
  parameter int MAX_RETRY   = MAX_RETRY_D
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_HI_W-1:0]           cmp_addr_high,
  input  logic [ADDR_LO_W:0]             num_vectors,
  input  logic [NUM_SUB-1:0]             sub_mask,
  input  logic [DATA_W-1:0]              data_in,
  input  logic                           write_ack,
  output logic [NUM_SUB-1:0]             chip_enable,
  output logic [ADDR_HI_W+ADDR_LO_W-1:0] cmp_addr_reg,
  output logic [DATA_W-1:0]              wr_data,
  output logic                           busy,
  output logic                           done,
  output logic                           done_all,
  output logic                           error,
  output logic [$clog2(NUM_SUB)-1:0]     err_sub
);
  localparam int SW = $clog2(NUM_SUB);
  localparam int VW = ADDR_LO_W + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1) + 1;
  localparam int RW = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [VW-1:0] VMAX = VW'(1) << ADDR_LO_W;

  cam_seq_state_t state, state_nxt;
  logic                 start_q, ack_q;
  logic [ADDR_HI_W-1:0] bank_q;
  logic [VW-1:0]        nv_q, vec_idx, vec_nxt;
  logic [NUM_SUB-1:0]   mask_q;
  logic [SW:0]          sub_idx;
  logic [TW-1:0]        tmo;
  logic [RW-1:0]        retry;
  logic [SW-1:0]        found_idx;
  logic                 found, tmo_hit, ack_hit, last_vec, can_retry, accept;

  cam_mask_prio_enc #(.N(NUM_SUB)) u_prio (
    .mask      (mask_q),
    .start_idx (sub_idx),
    .found     (found),
    .idx       (found_idx)
  );

  assign vec_nxt   = vec_idx + 1'b1;
  assign last_vec  = vec_nxt >= nv_q;
  assign tmo_hit   = (ACK_TIMEOUT != 0) && (tmo == TW'(ACK_TIMEOUT - 1));
  // An ack arriving on the final timeout cycle is honoured rather than retried.
  assign ack_hit   = ack_q || (tmo_hit && write_ack);
  assign can_retry = retry < RW'(MAX_RETRY);
  assign accept    = start && !busy;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    done_all  = 1'b0;
    case (state)
      S_IDLE: begin
        busy = start_q;
        if (start_q) state_nxt = (nv_q == '0) ? S_FINISH : S_SEEK;
      end
      S_SEEK:     state_nxt = found ? S_WRITE : S_VEC_DONE;
      S_WRITE:    state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (ack_hit)      state_nxt = S_SEEK;
        else if (tmo_hit) state_nxt = can_retry ? S_WRITE : S_SEEK;
      end
      S_VEC_DONE: begin
        done      = 1'b1;
        state_nxt = last_vec ? S_FINISH : S_SEEK;
      end
      S_FINISH: begin
        busy      = 1'b0;
        done_all  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      start_q      <= 1'b0;
      ack_q        <= 1'b0;
      bank_q       <= '0;
      nv_q         <= '0;
      mask_q       <= '0;
      vec_idx      <= '0;
      sub_idx      <= '0;
      tmo          <= '0;
      retry        <= '0;
      chip_enable  <= '0;
      cmp_addr_reg <= '0;
      wr_data      <= '0;
      error        <= 1'b0;
      err_sub      <= '0;
    end else begin
      start_q <= accept;
      // Acks are only meaningful while a subarray is selected.
      ack_q   <= write_ack && (chip_enable != '0);
      case (state)
        S_IDLE: if (start_q) begin
          vec_idx <= '0;
          sub_idx <= '0;
          retry   <= '0;
        end
        S_SEEK: if (found) sub_idx <= {1'b0, found_idx};
        S_WRITE: begin
          chip_enable <= NUM_SUB'(1) << sub_idx[SW-1:0];
          wr_data     <= data_in;
          tmo         <= '0;
        end
        S_WAIT_ACK: begin
          if (ack_hit) begin
            chip_enable <= '0;
            retry       <= '0;
            sub_idx     <= sub_idx + 1'b1;
          end else if (tmo_hit) begin
            chip_enable <= '0;
            if (can_retry) retry <= retry + 1'b1;
            else begin
              retry   <= '0;
              sub_idx <= sub_idx + 1'b1;
              error   <= 1'b1;
              if (!error) err_sub <= sub_idx[SW-1:0];
            end
          end else if (ACK_TIMEOUT != 0) begin
            tmo <= tmo + 1'b1;
          end
        end
        S_VEC_DONE: if (!last_vec) begin
          vec_idx      <= vec_nxt;
          sub_idx      <= '0;
          cmp_addr_reg <= {bank_q, vec_nxt[ADDR_LO_W-1:0]};
        end
        default: ;
      endcase
      if (accept) begin
        bank_q       <= cmp_addr_high;
        nv_q         <= (num_vectors > VMAX) ? VMAX : num_vectors;
        mask_q       <= sub_mask;
        cmp_addr_reg <= {cmp_addr_high, {ADDR_LO_W{1'b0}}};
        error        <= 1'b0;
        err_sub      <= '0;
      end
    end
  end
endmodule
